// File: rtl/network_layer_rx_if.sv
// Link-side, user-side and credit-return signal bundle for network_layer_rx.
// The slave modport is the receiver's view; master is the surrounding fabric's view.
interface network_layer_rx_if #(
    parameter int unsigned DATA_WIDTH    = 128,
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned META_WIDTH    = 16,
    parameter int unsigned CONN_ID_WIDTH = 2,
    parameter int unsigned CREDIT_WIDTH  = 10
);
    logic [DATA_WIDTH-1:0]    link_data;
    logic                     link_valid;
    logic                     link_last;
    logic [CONN_ID_WIDTH-1:0] link_conn_id;
    logic                     link_ready;

    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_first;
    logic                     out_last;
    logic [ADDR_WIDTH-1:0]    out_dest_addr;
    logic [ADDR_WIDTH-1:0]    out_src_addr;
    logic [META_WIDTH-1:0]    out_metadata;
    logic                     out_controller;
    logic [CONN_ID_WIDTH-1:0] out_conn_id;

    logic                     credit_valid;
    logic [CONN_ID_WIDTH-1:0] credit_conn_id;
    logic [CREDIT_WIDTH-1:0]  credit_count;

    modport master (
        output link_data, link_valid, link_last, link_conn_id, out_ready,
        input  link_ready, out_data, out_valid, out_first, out_last, out_dest_addr,
               out_src_addr, out_metadata, out_controller, out_conn_id,
               credit_valid, credit_conn_id, credit_count
    );

    modport slave (
        input  link_data, link_valid, link_last, link_conn_id, out_ready,
        output link_ready, out_data, out_valid, out_first, out_last, out_dest_addr,
               out_src_addr, out_metadata, out_controller, out_conn_id,
               credit_valid, credit_conn_id, credit_count
    );
endinterface

// File: rtl/network_layer_rx.sv
// Receive network layer: parses header flits, buffers payload in a FWFT FIFO, batches credit returns.
// Define NET_RX_ADDR_FILTER_EN to drop packets whose destination device differs from my_device_id.
module network_layer_rx #(
    parameter int unsigned DATA_WIDTH      = 128,
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned META_WIDTH      = 16,
    parameter int unsigned DEVICE_ID_WIDTH = 10,
    parameter int unsigned USER_ID_WIDTH   = 4,
    parameter int unsigned CONN_ID_WIDTH   = 2,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned CREDIT_BATCH    = 16,
    parameter int unsigned CREDIT_WIDTH    = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DEVICE_ID_WIDTH-1:0] my_device_id,
    network_layer_rx_if.slave          nif,
    output logic [31:0]                drop_count
);
    localparam int unsigned NUM_CONN = 1 << CONN_ID_WIDTH;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {HEADER, PAYLOAD, DROP} state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    data;
        logic                     first;
        logic                     last;
        logic [ADDR_WIDTH-1:0]    dest;
        logic [ADDR_WIDTH-1:0]    src;
        logic [META_WIDTH-1:0]    meta;
        logic                     ctrl;
        logic [CONN_ID_WIDTH-1:0] conn;
    } word_t;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    dest_q, dest_d, src_q, src_d;
    logic [META_WIDTH-1:0]    meta_q, meta_d;
    logic                     ctrl_q, ctrl_d, first_q, first_d;
    logic [CONN_ID_WIDTH-1:0] conn_q, conn_d;
    logic                     link_ready_q, link_ready_d;
    logic [31:0]              drop_q, drop_d;

    word_t                    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]           count_q, count_d;

    logic [CREDIT_WIDTH-1:0]  acc_q [NUM_CONN];
    logic [CREDIT_WIDTH-1:0]  acc_d [NUM_CONN];
    logic [CREDIT_WIDTH-1:0]  inc   [NUM_CONN];
    logic                     credit_valid_q, credit_valid_d;
    logic [CONN_ID_WIDTH-1:0] credit_conn_q, credit_conn_d;
    logic [CREDIT_WIDTH-1:0]  credit_count_q, credit_count_d;

    logic                     accept, push, pop, out_valid, filtered;
    logic                     link_inc, flush_hit;
    logic [CONN_ID_WIDTH-1:0] link_inc_conn, flush_idx;
    logic [ADDR_WIDTH-1:0]    hdr_dest, hdr_src;
    logic [META_WIDTH-1:0]    hdr_meta;
    word_t                    push_word, rd_word;

    assign hdr_meta = nif.link_data[META_WIDTH-1:0];
    assign hdr_src  = nif.link_data[META_WIDTH +: ADDR_WIDTH];
    assign hdr_dest = nif.link_data[META_WIDTH+ADDR_WIDTH +: ADDR_WIDTH];

`ifdef NET_RX_ADDR_FILTER_EN
    assign filtered = hdr_dest[ADDR_WIDTH-1 -: DEVICE_ID_WIDTH] != my_device_id;
`else
    logic unused_dev_id;
    assign unused_dev_id = ^my_device_id;
    assign filtered      = 1'b0;
`endif

    assign accept    = nif.link_valid & link_ready_q;
    assign out_valid = count_q != '0;
    assign pop       = out_valid & nif.out_ready;
    assign rd_word   = out_valid ? mem_q[rd_ptr_q] : word_t'('0);
    assign push_word = '{data: nif.link_data, first: first_q, last: nif.link_last,
                         dest: dest_q, src: src_q, meta: meta_q, ctrl: ctrl_q, conn: conn_q};

    always_comb begin
        state_d       = state_q;
        dest_d        = dest_q;
        src_d         = src_q;
        meta_d        = meta_q;
        ctrl_d        = ctrl_q;
        conn_d        = conn_q;
        first_d       = first_q;
        drop_d        = drop_q;
        push          = 1'b0;
        link_inc      = 1'b0;
        link_inc_conn = conn_q;
        case (state_q)
            HEADER: if (accept) begin
                dest_d        = hdr_dest;
                src_d         = hdr_src;
                meta_d        = hdr_meta;
                ctrl_d        = hdr_dest[2 +: USER_ID_WIDTH] == '1;
                conn_d        = nif.link_conn_id;
                link_inc      = 1'b1;
                link_inc_conn = nif.link_conn_id;
                if (nif.link_last) begin
                    if (drop_q != '1) drop_d = drop_q + 32'd1;
                end else if (filtered) begin
                    state_d = DROP;
                end else begin
                    state_d = PAYLOAD;
                    first_d = 1'b1;
                end
            end
            PAYLOAD: if (accept) begin
                push    = 1'b1;
                first_d = 1'b0;
                if (nif.link_last) state_d = HEADER;
            end
            DROP: if (accept) begin
                link_inc = 1'b1;
                if (nif.link_last) begin
                    state_d = HEADER;
                    if (drop_q != '1) drop_d = drop_q + 32'd1;
                end
            end
            default: state_d = HEADER;
        endcase

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        // Registered ready looks ahead at next-cycle occupancy so a full FIFO never sees a push.
        link_ready_d = (state_d != PAYLOAD) || (count_d != (PTR_W+1)'(FIFO_DEPTH));

        flush_hit = 1'b0;
        flush_idx = '0;
        for (int unsigned c = 0; c < NUM_CONN; c++) begin
            if (!flush_hit && acc_q[c] >= CREDIT_WIDTH'(CREDIT_BATCH)) begin
                flush_hit = 1'b1;
                flush_idx = CONN_ID_WIDTH'(c);
            end
        end
        for (int unsigned c = 0; c < NUM_CONN; c++) begin
            inc[c] = '0;
            if (link_inc && link_inc_conn == CONN_ID_WIDTH'(c)) inc[c] = inc[c] + CREDIT_WIDTH'(1);
            if (pop && rd_word.conn == CONN_ID_WIDTH'(c))       inc[c] = inc[c] + CREDIT_WIDTH'(1);
            // A flushed accumulator keeps only this cycle's increments.
            if (flush_hit && flush_idx == CONN_ID_WIDTH'(c)) acc_d[c] = inc[c];
            else                                             acc_d[c] = acc_q[c] + inc[c];
        end
        credit_valid_d = flush_hit;
        credit_conn_d  = flush_idx;
        credit_count_d = flush_hit ? acc_q[flush_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= HEADER;
            dest_q         <= '0;
            src_q          <= '0;
            meta_q         <= '0;
            ctrl_q         <= 1'b0;
            conn_q         <= '0;
            first_q        <= 1'b0;
            link_ready_q   <= 1'b0;
            drop_q         <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            credit_valid_q <= 1'b0;
            credit_conn_q  <= '0;
            credit_count_q <= '0;
            for (int unsigned c = 0; c < NUM_CONN; c++) acc_q[c] <= '0;
        end else begin
            state_q        <= state_d;
            dest_q         <= dest_d;
            src_q          <= src_d;
            meta_q         <= meta_d;
            ctrl_q         <= ctrl_d;
            conn_q         <= conn_d;
            first_q        <= first_d;
            link_ready_q   <= link_ready_d;
            drop_q         <= drop_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            credit_valid_q <= credit_valid_d;
            credit_conn_q  <= credit_conn_d;
            credit_count_q <= credit_count_d;
            for (int unsigned c = 0; c < NUM_CONN; c++) acc_q[c] <= acc_d[c];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_word;
    end

    assign nif.link_ready     = link_ready_q;
    assign nif.out_valid      = out_valid;
    assign nif.out_data       = rd_word.data;
    assign nif.out_first      = rd_word.first;
    assign nif.out_last       = rd_word.last;
    assign nif.out_dest_addr  = rd_word.dest;
    assign nif.out_src_addr   = rd_word.src;
    assign nif.out_metadata   = rd_word.meta;
    assign nif.out_controller = rd_word.ctrl;
    assign nif.out_conn_id    = rd_word.conn;
    assign nif.credit_valid   = credit_valid_q;
    assign nif.credit_conn_id = credit_conn_q;
    assign nif.credit_count   = credit_count_q;
    assign drop_count         = drop_q;
endmodule

// File: tb/tb_network_layer_rx.sv
// Directed bench for network_layer_rx: table of single-word packets plus hand-written
// sequences for credits, backpressure, filtering (NET_RX_ADDR_FILTER_EN) and mid-packet reset.
module tb_network_layer_rx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  my_device_id = 10'd1;
    logic [31:0] drop_count;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    network_layer_rx_if nif ();

    network_layer_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .my_device_id (my_device_id),
        .nif          (nif),
        .drop_count   (drop_count)
    );

    typedef struct packed {
        logic [127:0] data;
        logic         first;
        logic         last;
        logic         ctrl;
        logic [1:0]   conn;
        logic [15:0]  dest;
        logic [15:0]  src;
        logic [15:0]  meta;
    } obs_t;

    typedef struct packed {
        logic [1:0] conn;
        logic [9:0] cnt;
    } cred_t;

    typedef struct {
        logic [9:0]   dev;
        logic [15:0]  dest;
        logic [15:0]  src;
        logic [15:0]  meta;
        logic [1:0]   conn;
        logic [127:0] data;
        logic         exp_ctrl;
    } vec_t;

    obs_t  q[$];
    cred_t cq[$];

    always @(negedge clk) begin
        if (rst_n && nif.out_valid && nif.out_ready)
            q.push_back('{data: nif.out_data, first: nif.out_first, last: nif.out_last,
                          ctrl: nif.out_controller, conn: nif.out_conn_id,
                          dest: nif.out_dest_addr, src: nif.out_src_addr, meta: nif.out_metadata});
        if (rst_n && nif.credit_valid)
            cq.push_back('{conn: nif.credit_conn_id, cnt: nif.credit_count});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] hdr(input logic [15:0] d, input logic [15:0] s, input logic [15:0] m);
        return {{5{16'hA5C3}}, d, s, m};
    endfunction

    task automatic send(input logic [127:0] d, input logic last, input logic [1:0] conn);
        int unsigned n = 0;
        nif.link_valid   = 1'b1;
        nif.link_data    = d;
        nif.link_last    = last;
        nif.link_conn_id = conn;
        while (!nif.link_ready && n < 200) begin
            tick();
            n++;
        end
        if (!nif.link_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: link_ready stayed 0, required 1 within 200 cycles");
        end
        tick();
        nif.link_valid = 1'b0;
        nif.link_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while (nif.out_valid && n < 100) begin
            tick();
            n++;
        end
        if (nif.out_valid) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: out_valid stayed 1, required 0 within 100 cycles");
        end
    endtask

    task automatic reset_dut();
        rst_n          = 1'b0;
        nif.link_valid = 1'b0;
        nif.link_last  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        q.delete();
        cq.delete();
    endtask

    task automatic header_only_burst(input int n, input logic [1:0] conn);
        for (int i = 0; i < n; i++) send(hdr(16'h0044, 16'h0000, 16'h0000), 1'b1, conn);
    endtask

    initial begin
        vec_t  vecs [6];
        obs_t  w;
        int    c1;

        vecs[0] = '{dev: 10'd1,   dest: 16'h0044, src: 16'h1230, meta: 16'hBEEF, conn: 2'd2,
                    data: 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, exp_ctrl: 1'b0};
        vecs[1] = '{dev: 10'd0,   dest: 16'h003C, src: 16'h0001, meta: 16'h0002, conn: 2'd0,
                    data: 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, exp_ctrl: 1'b1};
        vecs[2] = '{dev: 10'd1,   dest: 16'h0078, src: 16'hABCD, meta: 16'h1357, conn: 2'd3,
                    data: 128'h1, exp_ctrl: 1'b0};
        vecs[3] = '{dev: 10'd1,   dest: 16'h007F, src: 16'h4444, meta: 16'h5555, conn: 2'd1,
                    data: 128'hDEAD_BEEF, exp_ctrl: 1'b1};
        vecs[4] = '{dev: 10'h3FF, dest: 16'hFFFC, src: 16'hFFFF, meta: 16'hFFFF, conn: 2'd2,
                    data: {128{1'b1}}, exp_ctrl: 1'b1};
        vecs[5] = '{dev: 10'h2A5, dest: 16'hA954, src: 16'h0F0F, meta: 16'hF0F0, conn: 2'd1,
                    data: 128'h8000_0000_0000_0000_0000_0000_0000_0001, exp_ctrl: 1'b0};

        nif.link_valid   = 1'b0;
        nif.link_last    = 1'b0;
        nif.link_data    = '0;
        nif.link_conn_id = '0;
        nif.out_ready    = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_link_ready",   128'(nif.link_ready),   128'(0));
        check("rst_out_valid",    128'(nif.out_valid),    128'(0));
        check("rst_credit_valid", 128'(nif.credit_valid), 128'(0));
        check("rst_credit_count", 128'(nif.credit_count), 128'(0));
        check("rst_drop_count",   128'(drop_count),       128'(0));
        check("rst_out_data",     128'(nif.out_data),     128'(0));
        rst_n = 1'b1;
        tick();
        check("post_rst_link_ready", 128'(nif.link_ready), 128'(1));

        // Table: one header plus one payload word each
        for (int i = 0; i < 6; i++) begin
            my_device_id = vecs[i].dev;
            q.delete();
            send(hdr(vecs[i].dest, vecs[i].src, vecs[i].meta), 1'b0, vecs[i].conn);
            send(vecs[i].data, 1'b1, vecs[i].conn);
            wait_drain();
            check($sformatf("vec%0d_words", i), 128'(q.size()), 128'(1));
            if (q.size() > 0) begin
                w = q.pop_front();
                check($sformatf("vec%0d_data", i), w.data, vecs[i].data);
                check($sformatf("vec%0d_hdr", i), 128'({w.dest, w.src, w.meta}),
                      128'({vecs[i].dest, vecs[i].src, vecs[i].meta}));
                check($sformatf("vec%0d_ctrl", i), 128'(w.ctrl), 128'(vecs[i].exp_ctrl));
                check($sformatf("vec%0d_conn", i), 128'(w.conn), 128'(vecs[i].conn));
                check($sformatf("vec%0d_first_last", i), 128'({w.first, w.last}), 128'(2'b11));
            end
        end
        my_device_id = 10'd1;

        // 3-word packet on conn 2, then 12 zero-payload packets complete a 16-credit batch
        reset_dut();
        send(hdr(16'h0044, 16'h1230, 16'hBEEF), 1'b0, 2'd2);
        for (int i = 1; i <= 3; i++) send(128'(i), i == 3, 2'd2);
        wait_drain();
        check("p3_words", 128'(q.size()), 128'(3));
        for (int i = 0; i < 3 && q.size() > 0; i++) begin
            w = q.pop_front();
            check($sformatf("p3_w%0d_data", i), w.data, 128'(i + 1));
            check($sformatf("p3_w%0d_first_last", i), 128'({w.first, w.last}),
                  128'({i == 0, i == 2}));
            check($sformatf("p3_w%0d_ctrl_conn", i), 128'({w.ctrl, w.conn}), 128'({1'b0, 2'd2}));
            check($sformatf("p3_w%0d_hdr", i), 128'({w.dest, w.src, w.meta}),
                  128'({16'h0044, 16'h1230, 16'hBEEF}));
        end
        check("p3_no_flush", 128'(cq.size()), 128'(0));
        header_only_burst(12, 2'd2);
        tick();
        tick();
        tick();
        check("p3_flush_pulses", 128'(cq.size()), 128'(1));
        if (cq.size() > 0) check("p3_flush", 128'({cq[0].conn, cq[0].cnt}), 128'({2'd2, 10'd16}));
        check("p3_drop_count", 128'(drop_count), 128'(12));

        // Backpressure: 20-word payload with out_ready low
        reset_dut();
        nif.out_ready = 1'b0;
        send(hdr(16'h0044, 16'h2222, 16'h3333), 1'b0, 2'd0);
        for (int i = 1; i <= 16; i++) send(128'(i), 1'b0, 2'd0);
        check("bp_ready_full", 128'(nif.link_ready), 128'(0));
        nif.link_valid = 1'b1;
        nif.link_data  = 128'(17);
        tick();
        tick();
        tick();
        check("bp_ready_held", 128'(nif.link_ready), 128'(0));
        check("bp_out_valid",  128'(nif.out_valid),  128'(1));
        check("bp_no_pop",     128'(q.size()),       128'(0));
        nif.out_ready = 1'b1;
        for (int i = 17; i <= 20; i++) send(128'(i), i == 20, 2'd0);
        wait_drain();
        check("bp_words", 128'(q.size()), 128'(20));
        for (int i = 1; i <= 20 && q.size() > 0; i++) begin
            w = q.pop_front();
            check($sformatf("bp_w%0d", i), 128'({w.data[7:0], w.first, w.last}),
                  128'({8'(i), i == 1, i == 20}));
        end

        // 16 one-payload packets on conn 1: 32 credits, exactly one batch flushed
        reset_dut();
        for (int k = 0; k < 16; k++) begin
            send(hdr(16'h0044, 16'h0101, 16'h0202), 1'b0, 2'd1);
            send(128'(k), 1'b1, 2'd1);
        end
        wait_drain();
        tick();
        tick();
        tick();
        check("cr_words", 128'(q.size()), 128'(16));
        check("cr_flush_pulses", 128'(cq.size()), 128'(1));
        c1 = 0;
        if (cq.size() > 0) begin
            c1 = int'(cq[0].cnt);
            check("cr_flush_conn", 128'(cq[0].conn), 128'(1));
            check("cr_flush_ge16", 128'(c1 >= 16), 128'(1));
        end
        // Top up the retained remainder (32 - c1) to exactly 16
        header_only_burst((c1 > 16) ? c1 - 16 : 0, 2'd1);
        tick();
        tick();
        tick();
        check("cr_remainder_pulses", 128'(cq.size()), 128'(2));
        if (cq.size() > 1)
            check("cr_remainder", 128'({cq[1].conn, cq[1].cnt}), 128'({2'd1, 10'd16}));

        // Device mismatch: dest device 2 vs my_device_id 1, 5-flit packet on conn 3
        reset_dut();
        my_device_id = 10'd1;
        send(hdr(16'h0080, 16'h0011, 16'h2222), 1'b0, 2'd3);
        for (int i = 1; i <= 4; i++) send(128'(i), i == 4, 2'd3);
        wait_drain();
        tick();
`ifdef NET_RX_ADDR_FILTER_EN
        check("flt_words", 128'(q.size()),   128'(0));
        check("flt_drop",  128'(drop_count), 128'(1));
`else
        check("flt_words", 128'(q.size()),   128'(4));
        check("flt_drop",  128'(drop_count), 128'(0));
`endif
        header_only_burst(11, 2'd3);
        tick();
        tick();
        tick();
        check("flt_flush_pulses", 128'(cq.size()), 128'(1));
        if (cq.size() > 0) check("flt_flush", 128'({cq[0].conn, cq[0].cnt}), 128'({2'd3, 10'd16}));
`ifdef NET_RX_ADDR_FILTER_EN
        check("flt_drop_total", 128'(drop_count), 128'(12));
`else
        check("flt_drop_total", 128'(drop_count), 128'(11));
`endif

        // One-cycle reset in the middle of a payload
        reset_dut();
        nif.out_ready = 1'b0;
        send(hdr(16'h0044, 16'h1111, 16'h2222), 1'b0, 2'd2);
        send(128'hAA, 1'b0, 2'd2);
        send(128'hBB, 1'b0, 2'd2);
        check("mr_buffered", 128'(nif.out_valid), 128'(1));
        rst_n = 1'b0;
        tick();
        check("mr_out_valid",  128'(nif.out_valid),  128'(0));
        check("mr_link_ready", 128'(nif.link_ready), 128'(0));
        rst_n = 1'b1;
        tick();
        nif.out_ready = 1'b1;
        q.delete();
        send(hdr(16'h0044, 16'h5678, 16'h9ABC), 1'b0, 2'd1);
        send(128'h77, 1'b1, 2'd1);
        wait_drain();
        check("mr_words", 128'(q.size()), 128'(1));
        if (q.size() > 0) begin
            w = q.pop_front();
            check("mr_data", w.data, 128'h77);
            check("mr_hdr", 128'({w.dest, w.src, w.meta, w.conn, w.first, w.last}),
                  128'({16'h0044, 16'h5678, 16'h9ABC, 2'd1, 1'b1, 1'b1}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
